// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - IF lookup, ID resolve and statistics bundle for branch_predict_unit
`ifndef INST_ID_LEN
`define INST_ID_LEN 6
`endif

interface branch_predict_unit_if #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32,
    parameter int IMM_W  = 32,
    parameter int CNT_W  = 32
);
    logic [ADDR_W-1:0]       if_pc_i;
    logic                    if_pred_taken_o;
    logic [ADDR_W-1:0]       if_pred_target_o;
    logic                    id_valid_i;
    logic                    id_stall_i;
    logic [`INST_ID_LEN-1:0] instr_id_i;
    logic [ADDR_W-1:0]       id_pc_i;
    logic [IMM_W-1:0]        imm_i;
    logic [XLEN-1:0]         reg_rs1_val_i;
    logic [XLEN-1:0]         reg_rs2_val_i;
    logic [XLEN-1:0]         fwd_rs1_val_i;
    logic [XLEN-1:0]         fwd_rs2_val_i;
    logic                    fwd_rs1_we_i;
    logic                    fwd_rs2_we_i;
    logic                    id_pred_taken_i;
    logic [ADDR_W-1:0]       id_pred_target_i;
    logic                    redirect_o;
    logic [ADDR_W-1:0]       redirect_pc_o;
    logic [CNT_W-1:0]        branch_cnt_o;
    logic [CNT_W-1:0]        mispredict_cnt_o;

    // Pipeline side: drives PCs and decoded operands, consumes predictions and redirects
    modport master (
        output if_pc_i, id_valid_i, id_stall_i, instr_id_i, id_pc_i, imm_i,
               reg_rs1_val_i, reg_rs2_val_i, fwd_rs1_val_i, fwd_rs2_val_i,
               fwd_rs1_we_i, fwd_rs2_we_i, id_pred_taken_i, id_pred_target_i,
        input  if_pred_taken_o, if_pred_target_o, redirect_o, redirect_pc_o,
               branch_cnt_o, mispredict_cnt_o
    );

    // Predictor side
    modport slave (
        input  if_pc_i, id_valid_i, id_stall_i, instr_id_i, id_pc_i, imm_i,
               reg_rs1_val_i, reg_rs2_val_i, fwd_rs1_val_i, fwd_rs2_val_i,
               fwd_rs1_we_i, fwd_rs2_we_i, id_pred_taken_i, id_pred_target_i,
        output if_pred_taken_o, if_pred_target_o, redirect_o, redirect_pc_o,
               branch_cnt_o, mispredict_cnt_o
    );
endinterface

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB/BHT predictor with ID-stage branch resolution
`ifndef INST_ID_LEN
`define INST_ID_LEN 6
`endif
`ifndef ID_JAL
`define ID_JAL  6'd1
`define ID_JALR 6'd2
`define ID_BEQ  6'd3
`define ID_BNE  6'd4
`define ID_BLT  6'd5
`define ID_BGE  6'd6
`define ID_BLTU 6'd7
`define ID_BGEU 6'd8
`endif

module branch_predict_unit #(
    parameter int ADDR_W  = 32,
    parameter int XLEN    = 32,
    parameter int IMM_W   = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input logic                 clk,
    input logic                 rst,
    branch_predict_unit_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] jump_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [CNT_W-1:0]   branch_cnt_q;
    logic [CNT_W-1:0]   mispredict_cnt_q;

    logic [IDX_W-1:0]  if_idx, id_idx;
    logic [TAG_W-1:0]  if_tag, id_tag;
    logic              if_hit, if_taken, id_hit;
    logic [XLEN-1:0]   rs1, rs2;
    logic [ADDR_W-1:0] imm_ext, pc_plus4, target, actual_next, pred_next;
    logic              is_cf, is_jump, is_jalr, taken, active, redirect;
    logic              unused_pc_bits;

    assign if_idx = bus.if_pc_i[IDX_W+1:2];
    assign if_tag = bus.if_pc_i[ADDR_W-1:IDX_W+2];
    assign id_idx = bus.id_pc_i[IDX_W+1:2];
    assign id_tag = bus.id_pc_i[ADDR_W-1:IDX_W+2];
    assign unused_pc_bits = ^{bus.if_pc_i[1:0], bus.id_pc_i[1:0]};

    // IF lookup reads registered tables, so a same-cycle update is never visible here
    always_comb begin
        if_hit   = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        if_taken = !rst && if_hit && (jump_q[if_idx] || ctr_q[if_idx][1]);
        bus.if_pred_taken_o  = if_taken;
        bus.if_pred_target_o = if_taken ? target_q[if_idx] : '0;
    end

    // ID resolve: operand select, condition evaluation, target and redirect decision
    always_comb begin
        rs1      = bus.fwd_rs1_we_i ? bus.fwd_rs1_val_i : bus.reg_rs1_val_i;
        rs2      = bus.fwd_rs2_we_i ? bus.fwd_rs2_val_i : bus.reg_rs2_val_i;
        imm_ext  = ADDR_W'($signed(bus.imm_i));
        pc_plus4 = bus.id_pc_i + ADDR_W'(4);
        is_cf    = 1'b1;
        is_jump  = 1'b0;
        is_jalr  = 1'b0;
        taken    = 1'b0;
        case (bus.instr_id_i)
            `ID_JAL:  begin is_jump = 1'b1; taken = 1'b1; end
            `ID_JALR: begin is_jump = 1'b1; is_jalr = 1'b1; taken = 1'b1; end
            `ID_BEQ:  taken = (rs1 == rs2);
            `ID_BNE:  taken = (rs1 != rs2);
            `ID_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            `ID_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            `ID_BLTU: taken = (rs1 <  rs2);
            `ID_BGEU: taken = (rs1 >= rs2);
            default:  is_cf = 1'b0;
        endcase
        target      = is_jalr ? ((ADDR_W'(rs1) + imm_ext) & ~ADDR_W'(1))
                              : (bus.id_pc_i + imm_ext);
        actual_next = taken ? target : pc_plus4;
        pred_next   = bus.id_pred_taken_i ? bus.id_pred_target_i : pc_plus4;
        active      = bus.id_valid_i && !bus.id_stall_i && !rst;
        id_hit      = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
        redirect    = active && (is_cf ? (actual_next != pred_next) : bus.id_pred_taken_i);
        bus.redirect_o    = redirect;
        bus.redirect_pc_o = !redirect ? '0 : (is_cf ? actual_next : pc_plus4);
    end

    assign bus.branch_cnt_o     = branch_cnt_q;
    assign bus.mispredict_cnt_o = mispredict_cnt_q;

    // Table training and statistics on each resolved, unstalled instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q          <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
        end else if (active) begin
            if (is_cf) begin
                if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
                if (taken) begin
                    target_q[id_idx] <= target;
                    jump_q[id_idx]   <= is_jump;
                    if (id_hit) begin
                        if (ctr_q[id_idx] != 2'b11) ctr_q[id_idx] <= ctr_q[id_idx] + 2'b01;
                    end else begin
                        valid_q[id_idx] <= 1'b1;
                        tag_q[id_idx]   <= id_tag;
                        ctr_q[id_idx]   <= 2'b10;
                    end
                end else if (id_hit && ctr_q[id_idx] != 2'b00) begin
                    ctr_q[id_idx] <= ctr_q[id_idx] - 2'b01;
                end
            end else if (bus.id_pred_taken_i && tag_q[id_idx] == id_tag) begin
                valid_q[id_idx] <= 1'b0;
            end
            if (redirect && mispredict_cnt_q != '1) mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
        end
    end
endmodule
